// File: rtl/parity_frame_ctrl.sv
// -----------------------------------------------------------------------------
// parity_frame_ctrl
//
// Serial frame sequencer for a running-parity transmit path. A parallel word is
// taken over a valid/ready handshake, shifted out LSB-first one bit per cycle
// while a running parity accumulator (acc <= acc ^ bit) folds in every data bit
// consumed, and the generated parity bit is appended after the data bits.
// Every output is decoded from registered state only; no input reaches an
// output combinationally.
//
// Parameters:
//   DATA_W  data bits per frame (2..32)
//   ODD     parity sense: 1 = odd (data+parity has an odd number of ones),
//           0 = even
//
// Optional feature (compile-time macro STOP_BIT_EN):
//   defined   -> a stop bit (constant 1) follows the parity bit; frame_end
//                moves from the parity bit to the stop bit; frame length is
//                DATA_W+2.
//   undefined -> the frame ends at the parity bit; frame length is DATA_W+1.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   reset_n      asynchronous active-low reset; abandons any frame in flight
//   in_valid     source presents in_data
//   in_ready     controller can accept a word (IDLE only)
//   in_data      parallel word, captured on the handshake edge
//   ser_stall    sink back-pressure; freezes the current bit and all state
//   ser_out      serial bit presented this cycle
//   ser_valid    ser_out carries a frame bit
//   frame_start  first data bit is being presented
//   frame_end    last bit of the frame is being presented
//   par_run      running parity accumulator (XOR of data bits consumed so far)
//   busy         controller is not in IDLE
// -----------------------------------------------------------------------------
module parity_frame_ctrl #(
    parameter int DATA_W = 8,
    parameter int ODD    = 1
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              ser_stall,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              par_run,
    output logic              busy
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic            ODD_BIT  = (ODD != 0);

`ifdef STOP_BIT_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_STOP = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              acc_q,   acc_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, independent of
    // process ordering in simulation.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a hold-value default first; a path
    // that left one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;

        case (state_q)
            S_IDLE: begin
                // ser_stall has no meaning before a frame starts.
                if (in_valid) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (!ser_stall) begin
                    acc_d   = acc_q ^ shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    // The counter parks on the last index instead of wrapping.
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_PAR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_PAR: begin
                // The accumulator is kept so par_run still reports the full
                // data parity until the next word is accepted.
                if (!ser_stall) begin
`ifdef STOP_BIT_EN
                    state_d = S_STOP;
`else
                    state_d = S_IDLE;
`endif
                end
            end

`ifdef STOP_BIT_EN
            S_STOP: begin
                if (!ser_stall) begin
                    state_d = S_IDLE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;

        case (state_q)
            S_DATA: begin
                ser_out     = shift_q[0];
                ser_valid   = 1'b1;
                frame_start = (cnt_q == '0);
            end

            S_PAR: begin
                // Odd parity inverts the data XOR so the ones count comes out odd.
                ser_out   = acc_q ^ ODD_BIT;
                ser_valid = 1'b1;
`ifndef STOP_BIT_EN
                frame_end = 1'b1;
`endif
            end

`ifdef STOP_BIT_EN
            S_STOP: begin
                ser_out   = 1'b1;
                ser_valid = 1'b1;
                frame_end = 1'b1;
            end
`endif

            default: begin
            end
        endcase
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign par_run  = acc_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_ctrl
//
// Self-checking bench for parity_frame_ctrl (DATA_W=8). Two instances share one
// stimulus stream: u_odd (ODD=1) and u_even (ODD=0). A frame-position model
// (word + index into the frame) predicts every output of both instances and is
// compared on every falling clock edge; directed frames additionally pin the
// model with hand-computed bit patterns. Honours STOP_BIT_EN like the design.
// -----------------------------------------------------------------------------
module tb_parity_frame_ctrl;

    localparam int DATA_W = 8;
`ifdef STOP_BIT_EN
    localparam int STOP = 1;
`else
    localparam int STOP = 0;
`endif
    localparam int NF = DATA_W + 1 + STOP;              // bits per frame
    localparam logic [31:0] STOP_BIT = (STOP != 0) ? (32'h1 << (DATA_W + 1)) : 32'h0;

    logic              CLK       = 1'b0;
    logic              reset_n   = 1'b1;
    logic              in_valid  = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              ser_stall = 1'b0;

    logic o_in_ready, o_ser_out, o_ser_valid, o_frame_start, o_frame_end, o_par_run, o_busy;
    logic e_in_ready, e_ser_out, e_ser_valid, e_frame_start, e_frame_end, e_par_run, e_busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 CLK = ~CLK;

    parity_frame_ctrl #(.DATA_W(DATA_W), .ODD(1)) u_odd (
        .CLK(CLK), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(o_in_ready), .in_data(in_data),
        .ser_stall(ser_stall), .ser_out(o_ser_out), .ser_valid(o_ser_valid),
        .frame_start(o_frame_start), .frame_end(o_frame_end),
        .par_run(o_par_run), .busy(o_busy)
    );

    parity_frame_ctrl #(.DATA_W(DATA_W), .ODD(0)) u_even (
        .CLK(CLK), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(e_in_ready), .in_data(in_data),
        .ser_stall(ser_stall), .ser_out(e_ser_out), .ser_valid(e_ser_valid),
        .frame_start(e_frame_start), .frame_end(e_frame_end),
        .par_run(e_par_run), .busy(e_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: which word is in flight and which frame position
    // (0..NF-1) is on the line.
    // -------------------------------------------------------------------------
    logic              m_idle = 1'b1;
    int                m_pos  = 0;
    logic [DATA_W-1:0] m_word = '0;
    logic              m_last = 1'b0;   // par_run seen while idle

    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            m_idle <= 1'b1;
            m_pos  <= 0;
            m_last <= 1'b0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_word <= in_data;
                m_pos  <= 0;
                m_idle <= 1'b0;
            end
        end else if (!ser_stall) begin
            if (m_pos == NF - 1) begin
                m_idle <= 1'b1;
                m_last <= ^m_word;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    function automatic logic exp_bit(input logic odd);
        if (m_idle)          return 1'b0;
        if (m_pos < DATA_W)  return m_word[m_pos];
        if (m_pos == DATA_W) return (^m_word) ^ odd;
        return 1'b1;
    endfunction

    function automatic logic exp_par_run();
        logic a;
        a = 1'b0;
        if (m_idle) return m_last;
        for (int i = 0; i < DATA_W && i < m_pos; i++) a ^= m_word[i];
        return a;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            check("odd.ser_valid",   o_ser_valid,   !m_idle);
            check("odd.ser_out",     o_ser_out,     exp_bit(1'b1));
            check("odd.in_ready",    o_in_ready,    m_idle);
            check("odd.busy",        o_busy,        !m_idle);
            check("odd.frame_start", o_frame_start, !m_idle && m_pos == 0);
            check("odd.frame_end",   o_frame_end,   !m_idle && m_pos == NF - 1);
            check("odd.par_run",     o_par_run,     exp_par_run());
            check("even.ser_valid",  e_ser_valid,   !m_idle);
            check("even.ser_out",    e_ser_out,     exp_bit(1'b0));
            check("even.in_ready",   e_in_ready,    m_idle);
            check("even.frame_start",e_frame_start, !m_idle && m_pos == 0);
            check("even.frame_end",  e_frame_end,   !m_idle && m_pos == NF - 1);
            check("even.par_run",    e_par_run,     exp_par_run());
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (drive at posedge+1, sample at posedge+2)
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!o_in_ready && t < 100) begin
            step();
            t++;
        end
        check("ready_timeout", o_in_ready, 1);
    endtask

    // Send one word, optionally stalling valid cycles st_at..st_at+st_len-1,
    // and record every valid cycle of both instances.
    task automatic run_frame(input logic [DATA_W-1:0] w, input int st_at, input int st_len,
                             output logic [31:0] b1, output logic [31:0] b0, output int nv,
                             output logic [31:0] fs, output logic [31:0] fe,
                             output logic p_first, output logic p_last);
        b1 = '0; b0 = '0; fs = '0; fe = '0; nv = 0; p_first = 1'b0; p_last = 1'b0;
        ser_stall = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (!o_ser_valid) break;
            if (nv < 32) begin
                b1[nv] = o_ser_out;
                b0[nv] = e_ser_out;
                fs[nv] = o_frame_start;
                fe[nv] = o_frame_end;
            end
            if (nv == 0) p_first = o_par_run;
            p_last    = o_par_run;
            ser_stall = (nv >= st_at) && (nv < st_at + st_len);
            nv++;
            step();
        end
        ser_stall = 1'b0;
    endtask

    initial begin
        logic [31:0] b1, b0, fs, fe, ev;
        logic [31:0] sv, so, rd;
        int          nv;
        logic        pf, pl;

        // Reset held with a word offered: nothing may start.
        #1;
        reset_n  = 1'b0;
        chk_en   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) begin
            step();
            check("rst.in_ready",  o_in_ready,  1);
            check("rst.busy",      o_busy,      0);
            check("rst.ser_valid", o_ser_valid, 0);
            check("rst.par_run",   o_par_run,   0);
        end
        reset_n = 1'b1;
        step();
        check("rst.first_valid", o_ser_valid,   1);
        check("rst.first_bit",   o_ser_out,     1);
        check("rst.first_start", o_frame_start, 1);
        in_valid = 1'b0;

        // 0xA5: bits 1,0,1,0,0,1,0,1 then odd parity 1 / even parity 0.
        run_frame(8'hA5, 0, 0, b1, b0, nv, fs, fe, pf, pl);
        check("a5.odd_bits",  b1, 32'h1A5 | STOP_BIT);
        check("a5.even_bits", b0, 32'h0A5 | STOP_BIT);
        check("a5.len",       nv, NF);
        check("a5.start",     fs, 32'h1);
        check("a5.end",       fe, 32'h1 << (NF - 1));
        check("a5.par_first", pf, 0);
        check("a5.par_last",  pl, 0);

        // 0x07: odd parity 0, even parity 1.
        run_frame(8'h07, 0, 0, b1, b0, nv, fs, fe, pf, pl);
        check("07.odd_bits",  b1, 32'h007 | STOP_BIT);
        check("07.even_bits", b0, 32'h107 | STOP_BIT);
        check("07.par_last",  pl, 1);

        // 0xFF with a 3-cycle stall on bit 4: 12 (or 13) valid cycles, all ones.
        run_frame(8'hFF, 4, 3, b1, b0, nv, fs, fe, pf, pl);
        check("ff_stall.len",  nv, NF + 3);
        check("ff_stall.bits", b1, (STOP != 0) ? 32'h1FFF : 32'h0FFF);
        check("ff_stall.end",  fe, 32'h1 << (NF + 2));

        // Stall on the first bit stretches frame_start; on the last, frame_end.
        run_frame(8'h3C, 0, 2, b1, b0, nv, fs, fe, pf, pl);
        check("stall_first.start", fs, 32'h7);
        check("stall_first.len",   nv, NF + 2);
        run_frame(8'h3C, NF - 1, 2, b1, b0, nv, fs, fe, pf, pl);
        check("stall_last.end",  fe, 32'h7 << (NF - 1));
        check("stall_last.bits", b1[DATA_W:0], 9'h13C);

        // Back-to-back with in_valid held: one IDLE cycle between frames.
        wait_ready();
        sv = '0; so = '0; rd = '0; ev = '0;
        in_valid = 1'b1;
        in_data  = 8'h01;
        step();
        in_data  = 8'h03;
        for (int i = 0; i < 2 * NF + 1; i++) begin
            #1;
            sv[i] = o_ser_valid;
            so[i] = o_ser_out;
            rd[i] = o_in_ready;
            ev[i] = (i != NF);
            if (i == NF + 1) in_valid = 1'b0;
            step();
        end
        in_valid = 1'b0;
        check("b2b.valid_pattern", sv, ev);
        check("b2b.gap_ready",     rd[NF], 1);
        check("b2b.par_01",        so[DATA_W], 0);
        check("b2b.par_03",        so[NF + 1 + DATA_W], 1);

        // Asynchronous reset in the middle of 0x5A, at bit 3.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        #1;
        check("midrst.pre_par_run", o_par_run, 1);
        check("midrst.pre_bit3",    o_ser_out, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst.ser_valid", o_ser_valid, 0);
        check("midrst.in_ready",  o_in_ready,  1);
        check("midrst.busy",      o_busy,      0);
        check("midrst.par_run",   o_par_run,   0);
        check("midrst.ser_out",   o_ser_out,   0);
        check("midrst.frame_end", o_frame_end, 0);
        check("midrst.even_vld",  e_ser_valid, 0);
        step();
        reset_n = 1'b1;
        run_frame(8'h5A, 0, 0, b1, b0, nv, fs, fe, pf, pl);
        check("after_rst.bits",      b1, 32'h15A | STOP_BIT);
        check("after_rst.len",       nv, NF);
        check("after_rst.par_first", pf, 0);
        check("after_rst.end",       fe, 32'h1 << (NF - 1));

        // Randomised traffic, stalls and occasional resets against the model.
        repeat (600) begin
            step();
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DATA_W'($urandom);
            ser_stall = ($urandom_range(0, 3) == 0);
            reset_n   = ($urandom_range(0, 199) != 0);
        end
        step();
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        ser_stall = 1'b0;
        repeat (2 * NF) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
